// File: rtl/alu_mdu_control_pkg.sv
// +----------------------------------------------------------------------+
// | alu_mdu_control_pkg: shared ALU/MDU encodings and decode helpers       |
// | Revision: 2.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_mdu_control_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ITYPE = 2'b11
  } aluop_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_t;

  localparam logic [2:0] INSTR_FUNC3_ADD  = 3'b000;
  localparam logic [2:0] INSTR_FUNC3_SLL  = 3'b001;
  localparam logic [2:0] INSTR_FUNC3_SLT  = 3'b010;
  localparam logic [2:0] INSTR_FUNC3_SLTU = 3'b011;
  localparam logic [2:0] INSTR_FUNC3_XOR  = 3'b100;
  localparam logic [2:0] INSTR_FUNC3_SR   = 3'b101;
  localparam logic [2:0] INSTR_FUNC3_OR   = 3'b110;
  localparam logic [2:0] INSTR_FUNC3_AND  = 3'b111;

  localparam logic [6:0] FUNC7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNC7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_t;

  function automatic alu_t base_alu_op(input logic [2:0] f3);
    alu_t op;
    case (f3)
      INSTR_FUNC3_ADD:  op = ALU_ADD;
      INSTR_FUNC3_SLL:  op = ALU_SLL;
      INSTR_FUNC3_SLT:  op = ALU_SLT;
      INSTR_FUNC3_SLTU: op = ALU_SLTU;
      INSTR_FUNC3_XOR:  op = ALU_XOR;
      INSTR_FUNC3_SR:   op = ALU_SRL;
      INSTR_FUNC3_OR:   op = ALU_OR;
      default:          op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mdu_control_op_decode.sv
// +----------------------------------------------------------------------+
// | alu_op_decode: combinational aluop/func3/func7 -> ALU op, M-op, illegal |
// | Revision: 2.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_op_decode
  import alu_mdu_control_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  aluop_t     aluop,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output alu_t       aluctr,
  output logic       is_m,
  output logic       illegal
);

  alu_t op;
  logic bad;
  logic m_op;

  always_comb begin
    op   = base_alu_op(func3);
    bad  = 1'b0;
    m_op = 1'b0;
    case (aluop)
      ALUOP_ADD: op = ALU_ADD;
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_RTYPE: begin
        case (func7)
          FUNC7_BASE: ;
          FUNC7_ALT: begin
            if (func3 == INSTR_FUNC3_ADD)     op = ALU_SUB;
            else if (func3 == INSTR_FUNC3_SR) op = ALU_SRA;
            else                              bad = 1'b1;
          end
          FUNC7_MULDIV: begin
            if (ENABLE_M) m_op = 1'b1;
            else          bad  = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      default: begin
        // Only immediate shifts carry meaningful func7 bits; other I-type ops hold immediate data there.
        if (func3 == INSTR_FUNC3_SLL) begin
          if (func7 != FUNC7_BASE) bad = 1'b1;
        end else if (func3 == INSTR_FUNC3_SR) begin
          if (func7 != FUNC7_BASE && func7 != FUNC7_ALT) bad = 1'b1;
          else if (func7[5])                            op  = ALU_SRA;
        end
      end
    endcase
  end

  assign aluctr  = (bad || m_op) ? ALU_ADD : op;
  assign is_m    = m_op;
  assign illegal = bad;

endmodule

`default_nettype wire

// File: rtl/alu_mdu_control.sv
// +----------------------------------------------------------------------+
// | alu_mdu_control: ALU decode plus multi-cycle MDU sequencer/handshake   |
// | Revision: 2.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_mdu_control
  import alu_mdu_control_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = XLEN,
  parameter bit ENABLE_M   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  aluop_t     aluop,
  input  logic       div_by_zero,
  input  logic       div_ovf,
  output logic       out_valid,
  input  logic       out_ready,
  output alu_t       aluctr,
  output logic       is_mdu,
  output mdu_op_t    mdu_op,
  output logic       mdu_start,
  output logic       mdu_step,
  output logic       mdu_last,
  output logic       mdu_special,
  output logic       illegal
);

  generate
    if (MUL_CYCLES < 1 || DIV_CYCLES < 1 || XLEN < 1) begin : g_bad_params
      $error("alu_mdu_control: XLEN, MUL_CYCLES and DIV_CYCLES must be >= 1");
    end
  endgenerate

  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  mdu_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             start_q;
  logic             special_q;
  mdu_op_t          op_q;
  logic             dec_is_m;
  logic             dec_illegal;
  logic             accept_m;
  logic             fast_path;

  alu_op_decode #(
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .aluop   (aluop),
    .func3   (func3),
    .func7   (func7),
    .aluctr  (aluctr),
    .is_m    (dec_is_m),
    .illegal (dec_illegal)
  );

  assign accept_m  = (state == ST_IDLE) && in_valid && dec_is_m && !flush;
  assign fast_path = func3[2] && (div_by_zero || div_ovf);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    is_mdu    = 1'b0;
    mdu_step  = 1'b0;
    mdu_last  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!flush) begin
          if (dec_is_m) begin
            in_ready = 1'b1;
          end else begin
            in_ready  = out_ready;
            out_valid = in_valid;
          end
        end
        if (accept_m) begin
          if (!func3[2]) begin
            state_nxt = ST_MUL;
            cnt_nxt   = MUL_LOAD;
          end else if (fast_path) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_DIV;
            cnt_nxt   = DIV_LOAD;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        is_mdu   = 1'b1;
        mdu_step = 1'b1;
        mdu_last = (cnt == '0);
        if (cnt == '0) state_nxt = ST_DONE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: begin
        is_mdu    = 1'b1;
        out_valid = !flush;
        if (out_ready) state_nxt = ST_IDLE;
      end
    endcase
    if (flush) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op_q      <= MDU_MUL;
      special_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      start_q <= accept_m && !fast_path;
      if (accept_m) begin
        op_q      <= mdu_op_t'(func3);
        special_q <= fast_path;
      end else if (flush || (state == ST_DONE && out_ready)) begin
        special_q <= 1'b0;
      end
    end
  end

  assign mdu_op      = op_q;
  assign mdu_special = special_q;
  assign mdu_start   = start_q;
  assign illegal     = (state == ST_IDLE) && dec_illegal;

endmodule

`default_nettype wire

// File: doc/alu_mdu_control.md
Name: alu_mdu_control

Overview:
Second-generation ALU control for the execute stage. It decodes aluop/func3/func7 into alu_t for single-cycle base-ISA ops, adds RV32M decode, and sequences the multi-cycle multiply/divide unit (MDU) with a counter-driven FSM. It applies valid/ready handshakes on both sides so the pipeline stalls while the MDU is busy. It also flags illegal func7/func3 encodings.

Parameters:
XLEN, 32, datapath width; reported to the MDU, and DIV_CYCLES defaults to it
MUL_CYCLES, 2, MDU step cycles for MUL/MULH/MULHSU/MULHU (>=1)
DIV_CYCLES, 32, MDU step cycles for DIV/DIVU/REM/REMU (>=1)
ENABLE_M, 1, 0 = M encodings decode as illegal and the FSM never leaves IDLE

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
flush  in  1  synchronous abort of any in-flight op
in_valid  in  1  decoded instruction fields valid
in_ready  out  1  block can accept
func3  in  3  instr[14:12]
func7  in  7  instr[31:25]
aluop  in  2 (aluop_t)  ADD/SUB/RTYPE/ITYPE class from control unit
div_by_zero  in  1  divisor == 0, sampled at accept
div_ovf  in  1  signed MIN / -1, sampled at accept
out_valid  out  1  result ready for writeback
out_ready  in  1  downstream accepts
aluctr  out  4 (alu_t)  ALU operation, combinational
is_mdu  out  1  output selects MDU result
mdu_op  out  3 (mdu_op_t)  latched M op (= func3)
mdu_start  out  1  one-cycle pulse, first busy cycle
mdu_step  out  1  iterate MDU this cycle
mdu_last  out  1  final step cycle
mdu_special  out  1  div-by-zero/overflow fast path; MDU forms the result from the operands
illegal  out  1  unsupported encoding, valid with out_valid

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, counter=0, mdu_op=0, and is_mdu, mdu_start, mdu_step, mdu_last, mdu_special, out_valid all 0.
- Decode (combinational in IDLE):
  - ADD -> ALU_ADD.
  - SUB -> ALU_SUB.
  - RTYPE with func7=0000000 -> base op from func3.
  - RTYPE with func7=0100000 -> ALU_SUB for func3=000, ALU_SRA for func3=101.
  - ITYPE -> base op from func3. func3=101 with func7[5]=1 -> ALU_SRA.
  - M op: aluop=RTYPE, func7=0000001, and ENABLE_M=1.
- Illegal encodings:
  - RTYPE with func7 outside {0000000, 0100000, 0000001}.
  - RTYPE with func7=0100000 and func3 not in {000, 101}.
  - ITYPE shift (func3 001/101) with func7 outside {0000000, 0100000}, or func3=001 with func7=0100000.
  - M op with ENABLE_M=0.
  - Any illegal encoding: aluctr=ALU_ADD, illegal=1, handled as single-cycle.
- Single-cycle path (IDLE, not M op): out_valid=in_valid and in_ready=out_ready, both combinational. No state change.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE accept (in_valid & in_ready) of an M op: in_ready=1 regardless of out_ready. Latch mdu_op=func3. Then:
  - func3[2]=0 -> MUL, counter=MUL_CYCLES-1.
  - func3[2]=1 with div_by_zero or div_ovf -> DONE with mdu_special=1 and no steps.
  - otherwise -> DIV, counter=DIV_CYCLES-1.
- MUL/DIV states:
  - in_ready=0, mdu_step=1.
  - mdu_start=1 only in the first busy cycle.
  - counter decrements each cycle. mdu_last=(counter==0).
  - When counter==0 -> DONE.
- DONE state: out_valid=1, is_mdu=1, in_ready=0. Hold until out_ready, then -> IDLE and clear mdu_special.
- Latency: accept at cycle T gives out_valid at T+MUL_CYCLES+1 (MUL) or T+DIV_CYCLES+1 (DIV). The special fast path gives T+1.
- Back-to-back: the IDLE entered after DONE may accept a new op in that same cycle. No bubble beyond the DONE handshake.
- flush: highest priority after reset. Next state=IDLE, counter=0, mdu_special=0, and no out_valid the following cycle. flush in IDLE suppresses any accept that cycle (in_ready=0).
- out_ready low in DONE: hold all outputs stable indefinitely.
- Counter width is $clog2(max(MUL_CYCLES,DIV_CYCLES)+1). Parameters <1 are an elaboration error.

Decomposition:
- Shared package (existing cpu package): aluop_t, alu_t, and INSTR_FUNC3_* constants already live there. Add:
  - mdu_op_t enum: MDU_MUL..MDU_REMU = func3 values 000-111.
  - FUNC7_BASE=0000000, FUNC7_ALT=0100000, FUNC7_MULDIV=0000001.
  - mdu_state_t.
- Sub-module alu_op_decode: the pure combinational func3/func7/aluop -> {aluctr, is_m, illegal} decode. The top level holds the FSM/counter and handshakes.

Test Plan:
- aluop=RTYPE, func7=0100000, func3=101, in_valid=1, out_ready=1 -> same cycle aluctr=ALU_SRA, out_valid=1, illegal=0, state stays IDLE.
- RTYPE func7=0000001 func3=000 accepted at T -> mdu_start=1 at T+1, mdu_step=1 at T+1..T+2, mdu_last at T+2, out_valid=1 with is_mdu=1 at T+3; in_ready=0 over T+1..T+3.
- func3=100 (DIV), div_by_zero=1 -> out_valid and mdu_special=1 at T+1, mdu_step never asserted. Repeat with DIV_CYCLES=32 and div_by_zero=0 -> out_valid at T+33.
- DIV in flight, flush at T+10 -> IDLE at T+11, no out_valid, next ADD accepted at T+11 with aluctr=ALU_ADD.
- DONE with out_ready=0 for 5 cycles -> out_valid and mdu_op stable. out_ready=1 -> IDLE next cycle, and a new MUL is accepted in that cycle.
- ITYPE func3=001, func7=0100000 -> illegal=1, aluctr=ALU_ADD. ENABLE_M=0 with func7=0000001 -> illegal=1, no mdu_start.
